// File: rtl/pipeline_hazard_controller_pkg.sv
// Shared types and encodings for the pipeline hazard controller.
// Holds the FSM state enum, the int_phase encodings and the address-width default.
package pipeline_hazard_controller_pkg;

    localparam int REG_ADDR_W_DEF = 4;

    typedef enum logic [1:0] {
        ST_RUN       = 2'd0,
        ST_MEM_WAIT  = 2'd1,
        ST_INT_DRAIN = 2'd2,
        ST_INT_PUSH  = 2'd3
    } state_t;

    localparam logic [1:0] INT_PHASE_NONE = 2'd0;
    localparam logic [1:0] INT_PHASE_LOW  = 2'd1;
    localparam logic [1:0] INT_PHASE_HIGH = 2'd2;

endpackage

// File: rtl/pipeline_hazard_controller_load_use.sv
// Combinational load-use detector: flags when the load in ID/EX writes a
// register that the instruction in IF/ID actually reads.
module load_use_detector
    import pipeline_hazard_controller_pkg::*;
#(
    parameter int REG_ADDR_W = REG_ADDR_W_DEF
) (
    input  logic                  i_idex_mem_read,
    input  logic [REG_ADDR_W-1:0] i_idex_rd,
    input  logic [REG_ADDR_W-1:0] i_ifid_rs1,
    input  logic [REG_ADDR_W-1:0] i_ifid_rs2,
    input  logic                  i_ifid_use_rs1,
    input  logic                  i_ifid_use_rs2,
    output logic                  o_load_use
);

    logic w_hit_rs1;
    logic w_hit_rs2;

    assign w_hit_rs1  = i_ifid_use_rs1 & (i_ifid_rs1 == i_idex_rd);
    assign w_hit_rs2  = i_ifid_use_rs2 & (i_ifid_rs2 == i_idex_rd);
    assign o_load_use = i_idex_mem_read & (w_hit_rs1 | w_hit_rs2);

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Pipeline hazard controller: memory-wait stalls, branch flushes, load-use
// stalls and a drain/push interrupt entry sequence, plus a saturating stall counter.
module pipeline_hazard_controller
    import pipeline_hazard_controller_pkg::*;
#(
    parameter int REG_ADDR_W   = REG_ADDR_W_DEF,
    parameter int DRAIN_CYCLES = 3,
    parameter int CNT_W        = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  idex_mem_read,
    input  logic [REG_ADDR_W-1:0] idex_rd,
    input  logic [REG_ADDR_W-1:0] ifid_rs1,
    input  logic [REG_ADDR_W-1:0] ifid_rs2,
    input  logic                  ifid_use_rs1,
    input  logic                  ifid_use_rs2,
    input  logic                  branch_taken,
    input  logic                  mem_req,
    input  logic                  mem_ready,
    input  logic                  int_req,
    output logic                  pc_stall,
    output logic                  ifid_stall,
    output logic                  idex_stall,
    output logic                  exmem_stall,
    output logic                  ifid_flush,
    output logic                  idex_flush,
    output logic                  memwb_bubble,
    output logic [1:0]            int_phase,
    output logic                  int_ack,
    output logic [CNT_W-1:0]      stall_count
);

    localparam int DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_CYCLES - 1);

    state_t               r_state;
    state_t               r_ret_state;
    state_t               w_next_state;
    logic                 r_int_pending;
    logic                 r_int_req_d;
    logic [DRAIN_W-1:0]   r_drain_cnt;
    logic                 r_push_phase;

    logic w_load_use;
    logic w_mem_wait;
    logic w_run_act;
    logic w_branch_act;
    logic w_lu_act;
    logic w_take_int;
    logic w_drain_act;
    logic w_drain_done;
    logic w_push_act;
    logic w_ack;

    load_use_detector #(
        .REG_ADDR_W (REG_ADDR_W)
    ) u_load_use (
        .i_idex_mem_read (idex_mem_read),
        .i_idex_rd       (idex_rd),
        .i_ifid_rs1      (ifid_rs1),
        .i_ifid_rs2      (ifid_rs2),
        .i_ifid_use_rs1  (ifid_use_rs1),
        .i_ifid_use_rs2  (ifid_use_rs2),
        .o_load_use      (w_load_use)
    );

    // Once waiting, only mem_ready ends the wait; memory wait outranks everything else.
    assign w_mem_wait   = (r_state == ST_MEM_WAIT) ? ~mem_ready : (mem_req & ~mem_ready);
    assign w_run_act    = (r_state == ST_RUN) & ~w_mem_wait;
    assign w_branch_act = w_run_act & branch_taken;
    assign w_lu_act     = w_run_act & ~branch_taken & w_load_use;
    assign w_take_int   = w_run_act & ~branch_taken & ~w_load_use & r_int_pending;
    assign w_drain_act  = (r_state == ST_INT_DRAIN) & ~w_mem_wait;
    assign w_drain_done = w_drain_act & (r_drain_cnt == DRAIN_LAST);
    assign w_push_act   = (r_state == ST_INT_PUSH) & ~w_mem_wait;
    assign w_ack        = w_push_act & r_push_phase;

    // State register and the state to resume after a memory wait.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_RUN;
            r_ret_state <= ST_RUN;
        end else begin
            r_state <= w_next_state;
            if (w_mem_wait && (r_state != ST_MEM_WAIT)) begin
                r_ret_state <= r_state;
            end
        end
    end

    // Next-state selection.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_RUN: begin
                if (w_mem_wait) begin
                    w_next_state = ST_MEM_WAIT;
                end else if (w_take_int) begin
                    w_next_state = ST_INT_DRAIN;
                end else begin
                    w_next_state = ST_RUN;
                end
            end
            ST_MEM_WAIT: begin
                if (w_mem_wait) begin
                    w_next_state = ST_MEM_WAIT;
                end else begin
                    w_next_state = r_ret_state;
                end
            end
            ST_INT_DRAIN: begin
                if (w_mem_wait) begin
                    w_next_state = ST_MEM_WAIT;
                end else if (w_drain_done) begin
                    w_next_state = ST_INT_PUSH;
                end else begin
                    w_next_state = ST_INT_DRAIN;
                end
            end
            ST_INT_PUSH: begin
                if (w_mem_wait) begin
                    w_next_state = ST_MEM_WAIT;
                end else if (r_push_phase) begin
                    w_next_state = ST_RUN;
                end else begin
                    w_next_state = ST_INT_PUSH;
                end
            end
            default: w_next_state = ST_RUN;
        endcase
    end

    // Output decode from state and current inputs.
    always_comb begin
        pc_stall     = w_mem_wait | w_lu_act | w_drain_act | w_push_act;
        ifid_stall   = w_mem_wait | w_lu_act;
        idex_stall   = w_mem_wait;
        exmem_stall  = w_mem_wait;
        memwb_bubble = w_mem_wait;
        ifid_flush   = w_branch_act | w_drain_act;
        idex_flush   = w_branch_act | w_lu_act;
        int_ack      = w_ack;
        if (w_push_act) begin
            int_phase = r_push_phase ? INT_PHASE_HIGH : INT_PHASE_LOW;
        end else begin
            int_phase = INT_PHASE_NONE;
        end
    end

    // Interrupt bookkeeping, drain/push progress and the saturating stall counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_int_pending <= 1'b0;
            r_int_req_d   <= 1'b0;
            r_drain_cnt   <= '0;
            r_push_phase  <= 1'b0;
            stall_count   <= '0;
        end else begin
            r_int_req_d <= int_req;
            if (w_ack) begin
                r_int_pending <= 1'b0;
            end else if ((r_state == ST_RUN) && int_req && !r_int_req_d) begin
                r_int_pending <= 1'b1;
            end
            if (w_drain_done) begin
                r_drain_cnt <= '0;
            end else if (w_drain_act) begin
                r_drain_cnt <= r_drain_cnt + DRAIN_W'(1);
            end
            if (w_ack) begin
                r_push_phase <= 1'b0;
            end else if (w_push_act) begin
                r_push_phase <= 1'b1;
            end
            if (pc_stall && (stall_count != {CNT_W{1'b1}})) begin
                stall_count <= stall_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Self-checking bench for pipeline_hazard_controller: directed scenarios then
// random stimulus, all compared cycle by cycle against a behavioural model.
module tb_pipeline_hazard_controller;

    localparam int AW    = 4;
    localparam int D     = 3;
    localparam int CW    = 10;
    localparam int CMAX  = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          idex_mem_read;
    logic [AW-1:0] idex_rd, ifid_rs1, ifid_rs2;
    logic          ifid_use_rs1, ifid_use_rs2;
    logic          branch_taken, mem_req, mem_ready, int_req;
    logic          pc_stall, ifid_stall, idex_stall, exmem_stall;
    logic          ifid_flush, idex_flush, memwb_bubble, int_ack;
    logic [1:0]    int_phase;
    logic [CW-1:0] stall_count;

    int n_checks = 0;
    int n_errors = 0;

    // Model: memory-wait flag, position in the interrupt sequence
    // (0 = normal running, 1..D = drain, D+1/D+2 = push), pending flag, counter.
    bit m_wait;
    int m_seq;
    bit m_pending;
    bit m_prev;
    int m_cnt;

    pipeline_hazard_controller #(
        .REG_ADDR_W   (AW),
        .DRAIN_CYCLES (D),
        .CNT_W        (CW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .idex_mem_read (idex_mem_read),
        .idex_rd       (idex_rd),
        .ifid_rs1      (ifid_rs1),
        .ifid_rs2      (ifid_rs2),
        .ifid_use_rs1  (ifid_use_rs1),
        .ifid_use_rs2  (ifid_use_rs2),
        .branch_taken  (branch_taken),
        .mem_req       (mem_req),
        .mem_ready     (mem_ready),
        .int_req       (int_req),
        .pc_stall      (pc_stall),
        .ifid_stall    (ifid_stall),
        .idex_stall    (idex_stall),
        .exmem_stall   (exmem_stall),
        .ifid_flush    (ifid_flush),
        .idex_flush    (idex_flush),
        .memwb_bubble  (memwb_bubble),
        .int_phase     (int_phase),
        .int_ack       (int_ack),
        .stall_count   (stall_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        idex_mem_read = 1'b0; idex_rd = '0; ifid_rs1 = '0; ifid_rs2 = '0;
        ifid_use_rs1 = 1'b0; ifid_use_rs2 = 1'b0; branch_taken = 1'b0;
        mem_req = 1'b0; mem_ready = 1'b0; int_req = 1'b0;
    endtask

    task automatic model_reset();
        m_wait = 1'b0; m_seq = 0; m_pending = 1'b0; m_prev = 1'b0; m_cnt = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
    endtask

    // One clock: compare outputs at the negedge, then advance the model.
    task automatic step(input string tag);
        bit wt, lu, take, in_run;
        bit e_pc, e_ifs, e_ids, e_exs, e_iff, e_idf, e_bub, e_ack;
        logic [1:0] e_ph;
        logic [9:0] exp_v, obs_v;
        @(negedge clk);
        wt = m_wait ? !mem_ready : (mem_req && !mem_ready);
        lu = idex_mem_read && ((ifid_use_rs1 && ifid_rs1 == idex_rd) ||
                               (ifid_use_rs2 && ifid_rs2 == idex_rd));
        in_run = !m_wait && (m_seq == 0);
        {e_pc, e_ifs, e_ids, e_exs, e_iff, e_idf, e_bub, e_ack} = 8'd0;
        e_ph = 2'd0;
        take = 1'b0;
        if (wt) begin
            {e_pc, e_ifs, e_ids, e_exs, e_bub} = 5'b11111;
        end else if (m_wait) begin
            e_pc = 1'b0;
        end else if (m_seq == 0) begin
            if (branch_taken) begin
                e_iff = 1'b1; e_idf = 1'b1;
            end else if (lu) begin
                e_pc = 1'b1; e_ifs = 1'b1; e_idf = 1'b1;
            end else begin
                take = m_pending;
            end
        end else if (m_seq <= D) begin
            e_pc = 1'b1; e_iff = 1'b1;
        end else if (m_seq == D + 1) begin
            e_pc = 1'b1; e_ph = 2'd1;
        end else begin
            e_pc = 1'b1; e_ph = 2'd2; e_ack = 1'b1;
        end
        exp_v = {e_pc, e_ifs, e_ids, e_exs, e_iff, e_idf, e_bub, e_ph, e_ack};
        obs_v = {pc_stall, ifid_stall, idex_stall, exmem_stall, ifid_flush,
                 idex_flush, memwb_bubble, int_phase, int_ack};
        check(tag, {22'd0, obs_v}, {22'd0, exp_v});
        check({tag, "_cnt"}, {22'd0, stall_count}, m_cnt);
        if (wt) m_wait = 1'b1;
        else if (m_wait) m_wait = 1'b0;
        else if (m_seq == 0) begin
            if (take) m_seq = 1;
        end else if (m_seq < D + 2) m_seq++;
        else begin
            m_seq = 0; m_pending = 1'b0;
        end
        if (in_run && int_req && !m_prev) m_pending = 1'b1;
        m_prev = int_req;
        if (e_pc && m_cnt != CMAX) m_cnt++;
        @(posedge clk); #1;
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        model_reset();
        do_reset();
        step("reset_idle");
        check("reset_cnt", {22'd0, stall_count}, 32'd0);

        // Load-use on rs2
        idex_mem_read = 1'b1; idex_rd = 4'd5; ifid_rs2 = 4'd5; ifid_use_rs2 = 1'b1;
        ifid_rs1 = 4'd2; ifid_use_rs1 = 1'b1;
        step("load_use");
        clear_inputs();
        step("load_use_after");
        check("load_use_cnt", {22'd0, stall_count}, 32'd1);

        // Branch overrides load-use
        do_reset();
        idex_mem_read = 1'b1; idex_rd = 4'd7; ifid_rs1 = 4'd7; ifid_use_rs1 = 1'b1;
        branch_taken = 1'b1;
        step("branch_lu");
        clear_inputs();
        step("branch_after");
        check("branch_cnt", {22'd0, stall_count}, 32'd0);

        // Memory wait of three cycles
        do_reset();
        mem_req = 1'b1; mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) step("mem_wait");
        mem_ready = 1'b1;
        step("mem_ready");
        clear_inputs();
        step("mem_after");
        check("mem_cnt", {22'd0, stall_count}, 32'd3);

        // Interrupt entry
        do_reset();
        int_req = 1'b1;
        step("int_edge");
        for (int i = 0; i < 7; i++) step("int_seq");
        check("int_cnt", {22'd0, stall_count}, 32'd5);
        int_req = 1'b0;
        step("int_done");

        // Memory wait in the second drain cycle
        do_reset();
        int_req = 1'b1;
        step("intw_edge");
        step("intw_take");
        step("intw_drain1");
        mem_req = 1'b1; mem_ready = 1'b0;
        step("intw_wait1");
        step("intw_wait2");
        mem_ready = 1'b1;
        step("intw_ready");
        mem_req = 1'b0; mem_ready = 1'b0;
        for (int i = 0; i < 5; i++) step("intw_seq");
        check("intw_cnt", {22'd0, stall_count}, 32'd7);

        // Reset while int_phase=1
        do_reset();
        int_req = 1'b1;
        step("intr_edge");
        for (int i = 0; i < 4; i++) step("intr_seq");
        rst = 1'b1;
        @(negedge clk);
        check("intr_phase", {30'd0, int_phase}, 32'd1);
        check("intr_ack", {31'd0, int_ack}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        clear_inputs();
        step("intr_after");
        check("intr_cnt", {22'd0, stall_count}, 32'd0);
        step("intr_after2");

        // Counter saturation
        do_reset();
        mem_req = 1'b1; mem_ready = 1'b0;
        for (int i = 0; i < (1 << CW) + 3; i++) step("sat");
        check("sat_cnt", {22'd0, stall_count}, CMAX);
        mem_ready = 1'b1;
        step("sat_ready");

        // Random traffic
        do_reset();
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 149) == 0) begin
                do_reset();
            end else begin
                idex_mem_read = 1'($urandom_range(0, 1));
                idex_rd       = 4'($urandom_range(0, 3));
                ifid_rs1      = 4'($urandom_range(0, 3));
                ifid_rs2      = 4'($urandom_range(0, 3));
                ifid_use_rs1  = 1'($urandom_range(0, 1));
                ifid_use_rs2  = 1'($urandom_range(0, 1));
                branch_taken  = ($urandom_range(0, 9) == 0);
                mem_req       = m_wait ? 1'b1 : ($urandom_range(0, 4) == 0);
                mem_ready     = 1'($urandom_range(0, 1));
                if ($urandom_range(0, 7) == 0) int_req = ~int_req;
                step("rand");
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_controller.md
PIPELINE_HAZARD_CONTROLLER -- requirements
Module: pipeline_hazard_controller

Interface
REQ-001 Parameters SHALL be, one per line as name, default, meaning:
  REG_ADDR_W, 4, register-address width.
  DRAIN_CYCLES, 3, interrupt pipeline-drain length, minimum 1.
  CNT_W, 16, stall-counter width.
REQ-002 Ports SHALL be, one per line as name, direction, width, meaning:
  clk  in  1  single clock; all state updates on posedge.
  rst  in  1  synchronous reset, active-high.
  idex_mem_read  in  1  ID/EX instruction is a load.
  idex_rd  in  REG_ADDR_W  ID/EX destination register.
  ifid_rs1, ifid_rs2  in  REG_ADDR_W  IF/ID source registers.
  ifid_use_rs1, ifid_use_rs2  in  1  the matching source is read.
  branch_taken  in  1  EX resolved a taken branch/jump.
  mem_req  in  1  MEM stage is accessing data memory.
  mem_ready  in  1  data memory completes this cycle.
  int_req  in  1  external interrupt request, level.
  pc_stall, ifid_stall, idex_stall, exmem_stall  out  1  hold the register.
  ifid_flush, idex_flush  out  1  load a bubble into the buffer.
  memwb_bubble  out  1  drives iamBubble into MEM/WB.
  int_phase  out  2  0 none, 1 push PC low, 2 push PC high.
  int_ack  out  1  one-cycle interrupt acknowledge.
  stall_count  out  CNT_W  saturating count of pc_stall cycles.

Function
REQ-003 The FSM SHALL have the states RUN, MEM_WAIT, INT_DRAIN and INT_PUSH; all control outputs SHALL be combinational from state and inputs, with state registered.
REQ-004 Every control output not driven high by REQ-005 to REQ-012 SHALL be 0.
REQ-005 Any state, mem_req=1 and mem_ready=0: pc_stall, ifid_stall, idex_stall and exmem_stall SHALL be 1 and memwb_bubble SHALL be 1 in the same cycle; the state SHALL move to MEM_WAIT, remembering the state it came from.
REQ-006 MEM_WAIT SHALL hold the REQ-005 outputs until a cycle with mem_ready=1; in that cycle all stalls SHALL be 0 and the state SHALL return to the remembered state. No other counter advances during MEM_WAIT.
REQ-007 Load-use in RUN is: idex_mem_read=1 and idex_rd equals a used IF/ID source. It SHALL assert pc_stall, ifid_stall and idex_flush for that cycle only.
REQ-008 branch_taken=1 in RUN SHALL assert ifid_flush and idex_flush for one cycle; branch SHALL override load-use, so no stall is asserted in that cycle.
REQ-009 Priority SHALL be rst > memory wait > branch > load-use > interrupt.
REQ-010 A rising edge of int_req SHALL set int_pending, and only in RUN. int_pending SHALL be taken in the first RUN cycle that has no memory wait, branch or load-use; that cycle SHALL enter INT_DRAIN.
REQ-011 INT_DRAIN SHALL last exactly DRAIN_CYCLES cycles, excluding MEM_WAIT cycles, with pc_stall=1 and ifid_flush=1. It SHALL then go to INT_PUSH.
REQ-012 INT_PUSH SHALL last 2 cycles with pc_stall=1, int_phase=1 then 2. int_ack=1 SHALL coincide with int_phase=2. int_pending SHALL clear on that cycle and the state SHALL then go to RUN.
REQ-013 int_req edges arriving outside RUN SHALL be ignored. branch_taken and load-use SHALL be ignored in the INT states.
REQ-014 stall_count SHALL increment on every cycle with pc_stall=1 and saturate at all-ones, with no wrap.

Reset
REQ-015 rst=1 at a posedge SHALL set state to RUN and clear int_pending, the drain counter, the push phase and stall_count. All outputs SHALL read 0 in the cycle after reset.
REQ-016 Reset in MEM_WAIT, INT_DRAIN or INT_PUSH SHALL abort the operation with no int_ack pulse.

Structure
REQ-017 A shared package SHALL hold the state enum, the int_phase encodings and the REG_ADDR_W default.
REQ-018 Source comparison SHALL be one combinational sub-module, load_use_detector. FSM, counters and output decode SHALL stay in the top module.

Verification
REQ-019 Load-use: idex_mem_read=1, idex_rd=5, ifid_rs2=5, ifid_use_rs2=1 -> pc_stall=ifid_stall=idex_flush=1 for one cycle; stall_count=1.
REQ-020 Branch plus load-use in the same cycle -> ifid_flush=idex_flush=1, pc_stall=0, stall_count unchanged.
REQ-021 mem_req=1 with mem_ready low for 3 cycles -> all four stalls and memwb_bubble=1 for 3 cycles, 0 in the mem_ready cycle; stall_count=3.
REQ-022 int_req rising in RUN, DRAIN_CYCLES=3 -> 3 drain cycles, then int_phase 1, then 2 with int_ack=1, then RUN; stall_count=5.
REQ-023 Memory wait during INT_DRAIN cycle 2 for 2 cycles -> drain still totals 3 non-wait cycles, then int_ack.
REQ-024 rst during int_phase=1 -> no int_ack, RUN next cycle, stall_count=0; saturation run: 2^CNT_W+3 stall cycles -> stall_count stays all-ones.
